tx_pcs_encoder: RTL and testbench

- Sits directly downstream of the TX MAC, on the PCS side of the 32-bit XGMII.
- Pairs consecutive 32-bit XGMII words into one 64-bit column (lanes 0-7).
- Encodes each column into an IEEE 802.3 Clause 49 64b/66b block.
- Presents the block to the gearbox with a valid/ready handshake, and drives the PCS-ready back-pressure seen by the MAC.

---
 rtl/tx_pcs_encoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_tx_pcs_encoder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pcs_encoder.sv
// tx_pcs_encoder: pairs 32-bit XGMII words into 64-bit columns and encodes
// each column as a 64b/66b block for the gearbox.
//
// Ports:
//   tx_clk, tx_rst           clock, async active-low reset
//   in_xgmii_data/ctl/valid  XGMII word from the MAC (valid is status only)
//   out_xgmii_pcs_ready      word accepted on every tx_clk edge where high
//   out_pcs_block(_valid)    66-bit block, [1:0] sync header, held until taken
//   in_gearbox_ready         gearbox takes the block when valid && ready
//   out_encode_error         one-cycle pulse per illegal column
//   out_error_count          saturating count of illegal columns
//
// Optional: define TX_PCS_SCRAMBLER_EN to scramble the payload with
// G(x) = 1 + x^39 + x^58 (sync header is never scrambled).
module tx_pcs_encoder #(
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     tx_clk,
    input  logic                     tx_rst,
    input  logic [31:0]              in_xgmii_data,
    input  logic [3:0]               in_xgmii_ctl,
    input  logic                     in_xgmii_valid,
    output logic                     out_xgmii_pcs_ready,
    output logic [65:0]              out_pcs_block,
    output logic                     out_pcs_block_valid,
    input  logic                     in_gearbox_ready,
    output logic                     out_encode_error,
    output logic [ERR_CNT_WIDTH-1:0] out_error_count
);

    localparam int unsigned LANES     = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CTL_W     = 4;
    localparam int unsigned PAYLOAD_W = 64;
    localparam int unsigned BLOCK_W   = 66;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_ERR   = 8'hFE;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;

    localparam logic [6:0] CODE_IDLE = 7'h00;
    localparam logic [6:0] CODE_ERR  = 7'h1E;

    localparam logic [7:0] TYPE_CTL = 8'h1E;
    localparam logic [7:0] TYPE_S0  = 8'h78;
    localparam logic [7:0] TYPE_S4  = 8'h33;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTL  = 2'b10;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    phase_t                   phase_q;
    phase_t                   phase_d;
    logic [WORD_W-1:0]        held_data;
    logic [CTL_W-1:0]         held_ctl;
    logic [PAYLOAD_W-1:0]     col_data;
    logic [LANES-1:0]         col_ctl;
    logic                     accept;
    logic                     load;
    logic                     all_ctl;
    logic                     term_hit;
    logic [2:0]               term_k;
    logic [1:0]               enc_sync;
    logic [PAYLOAD_W-1:0]     enc_payload;
    logic                     enc_err;
    logic [PAYLOAD_W-1:0]     tx_payload;
    logic                     unused_valid;

    // Frame-active flag is informational only.
    assign unused_valid = in_xgmii_valid;

    // Type byte for a terminate in lane k.
    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] t;
        case (k)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

    // Lane k holds /T/, lanes below are data, lanes above are idle control.
    function automatic logic is_term_at(input logic [PAYLOAD_W-1:0] d,
                                        input logic [LANES-1:0]     c,
                                        input int unsigned          k);
        logic ok;
        ok = (c == 8'(8'hFF << k)) && (d[8*k +: 8] == CH_TERM);
        for (int unsigned j = 0; j < LANES; j++) begin
            if (j > k && d[8*j +: 8] != CH_IDLE) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Word handshake: stall only when the second half would overwrite an untaken block.
    assign out_xgmii_pcs_ready = tx_rst &&
        !(phase_q == PH_HIGH && out_pcs_block_valid && !in_gearbox_ready);
    assign accept = out_xgmii_pcs_ready;
    assign load   = accept && (phase_q == PH_HIGH);

    assign col_data = {in_xgmii_data, held_data};
    assign col_ctl  = {in_xgmii_ctl, held_ctl};

    // Phase state register.
    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            phase_q <= PH_LOW;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase next-state.
    always_comb begin
        phase_d = phase_q;
        if (accept) begin
            phase_d = (phase_q == PH_LOW) ? PH_HIGH : PH_LOW;
        end
    end

    // Low half of the column.
    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            held_data <= '0;
            held_ctl  <= '0;
        end else if (accept && phase_q == PH_LOW) begin
            held_data <= in_xgmii_data;
            held_ctl  <= in_xgmii_ctl;
        end
    end

    // Every lane is a known control character (idle or error).
    always_comb begin
        all_ctl = (col_ctl == '1);
        for (int unsigned i = 0; i < LANES; i++) begin
            if (col_data[8*i +: 8] != CH_IDLE && col_data[8*i +: 8] != CH_ERR) begin
                all_ctl = 1'b0;
            end
        end
    end

    // Locate a legal terminate position.
    always_comb begin
        term_hit = 1'b0;
        term_k   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (is_term_at(col_data, col_ctl, k)) begin
                term_hit = 1'b1;
                term_k   = 3'(k);
            end
        end
    end

    // Column to block encoder.
    always_comb begin
        enc_sync    = SYNC_CTL;
        enc_payload = '0;
        enc_err     = 1'b0;
        if (col_ctl == '0) begin
            enc_sync    = SYNC_DATA;
            enc_payload = col_data;
        end else if (all_ctl) begin
            enc_payload[7:0] = TYPE_CTL;
            for (int unsigned i = 0; i < LANES; i++) begin
                enc_payload[8+7*i +: 7] = (col_data[8*i +: 8] == CH_ERR) ? CODE_ERR : CODE_IDLE;
            end
        end else if (col_ctl == 8'h01 && col_data[7:0] == CH_START) begin
            enc_payload = {col_data[63:8], TYPE_S0};
        end else if (col_ctl == 8'h1F && col_data[39:32] == CH_START &&
                     col_data[31:0] == {4{CH_IDLE}}) begin
            // Idle codes in lanes 0-3 are zero, so only lanes 5-7 carry data.
            enc_payload = {col_data[63:40], 32'h0, TYPE_S4};
        end else if (term_hit) begin
            enc_payload[7:0] = term_type(term_k);
            for (int unsigned i = 0; i < LANES - 1; i++) begin
                if (3'(i) < term_k) begin
                    enc_payload[8+8*i +: 8] = col_data[8*i +: 8];
                end
            end
        end else begin
            enc_err          = 1'b1;
            enc_payload[7:0] = TYPE_CTL;
            for (int unsigned i = 0; i < LANES; i++) begin
                enc_payload[8+7*i +: 7] = CODE_ERR;
            end
        end
    end

`ifdef TX_PCS_SCRAMBLER_EN
    logic [57:0] scr_q;

    // Serial scrambler unrolled over the 64 payload bits, bit 0 first.
    // ext[57:0] holds the previous 58 scrambled bits, oldest at index 0.
    function automatic logic [121:0] scramble(input logic [57:0] st,
                                              input logic [PAYLOAD_W-1:0] d);
        logic [121:0] ext;
        ext        = '0;
        ext[57:0]  = st;
        for (int unsigned i = 0; i < PAYLOAD_W; i++) begin
            ext[58+i] = d[i] ^ ext[i+19] ^ ext[i];
        end
        return ext;
    endfunction

    logic [121:0] scr_ext;
    assign scr_ext    = scramble(scr_q, enc_payload);
    assign tx_payload = scr_ext[121:58];

    // Scrambler state advances only on block load.
    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            scr_q <= '1;
        end else if (load) begin
            scr_q <= scr_ext[121:64];
        end
    end
`else
    assign tx_payload = enc_payload;
`endif

    // Output block register, error pulse and saturating error count.
    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            out_pcs_block       <= '0;
            out_pcs_block_valid <= 1'b0;
            out_encode_error    <= 1'b0;
            out_error_count     <= '0;
        end else begin
            out_encode_error <= 1'b0;
            if (load) begin
                out_pcs_block       <= BLOCK_W'({tx_payload, enc_sync});
                out_pcs_block_valid <= 1'b1;
                out_encode_error    <= enc_err;
                if (enc_err && out_error_count != '1) begin
                    out_error_count <= out_error_count + ERR_CNT_WIDTH'(1);
                end
            end else if (out_pcs_block_valid && in_gearbox_ready) begin
                out_pcs_block_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_pcs_encoder.sv
// Scoreboard bench for tx_pcs_encoder: a driver feeds one XGMII word per
// cycle and pushes the expected block per column; a monitor pops and compares.
module tb_tx_pcs_encoder;

    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          tx_clk = 1'b0;
    logic          tx_rst;
    logic [31:0]   in_xgmii_data;
    logic [3:0]    in_xgmii_ctl;
    logic          in_xgmii_valid;
    logic          out_xgmii_pcs_ready;
    logic [65:0]   out_pcs_block;
    logic          out_pcs_block_valid;
    logic          in_gearbox_ready;
    logic          out_encode_error;
    logic [CW-1:0] out_error_count;

    tx_pcs_encoder #(.ERR_CNT_WIDTH(CW)) dut (
        .tx_clk              (tx_clk),
        .tx_rst              (tx_rst),
        .in_xgmii_data       (in_xgmii_data),
        .in_xgmii_ctl        (in_xgmii_ctl),
        .in_xgmii_valid      (in_xgmii_valid),
        .out_xgmii_pcs_ready (out_xgmii_pcs_ready),
        .out_pcs_block       (out_pcs_block),
        .out_pcs_block_valid (out_pcs_block_valid),
        .in_gearbox_ready    (in_gearbox_ready),
        .out_encode_error    (out_encode_error),
        .out_error_count     (out_error_count)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [65:0] blk;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          model_cnt = 0;
    int          drv_phase = 0;
    bit          pending   = 0;
    logic [31:0] lo_word;
    logic [3:0]  lo_ctl;
    int          gb_mode   = 0;
    int          hold_left = 0;
    bit          ovr_en    = 0;
    logic [65:0] ovr_blk;
    bit          ovr_err;
    bit          mon_en    = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Reference encoder built directly from the 64b/66b column rules.
    function automatic logic [66:0] ref_encode(input logic [63:0] d, input logic [7:0] c);
        logic [7:0]  b [8];
        logic [7:0]  tcode [8];
        logic [63:0] p;
        logic [7:0]  tmask;
        bit          ok;
        tcode = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
        if (c == 8'h00) return {1'b0, d, 2'b01};
        ok = (c == 8'hFF);
        for (int i = 0; i < 8; i++) if (b[i] != 8'h07 && b[i] != 8'hFE) ok = 0;
        if (ok) begin
            p = 64'h1E;
            for (int i = 0; i < 8; i++) if (b[i] == 8'hFE) p = p | (64'h1E << (8 + 7*i));
            return {1'b0, p, 2'b10};
        end
        if (c == 8'h01 && b[0] == 8'hFB) return {1'b0, d[63:8], 8'h78, 2'b10};
        if (c == 8'h1F && b[4] == 8'hFB && b[0] == 8'h07 && b[1] == 8'h07 &&
            b[2] == 8'h07 && b[3] == 8'h07)
            return {1'b0, d[63:40], 32'h0, 8'h33, 2'b10};
        for (int k = 0; k < 8; k++) begin
            tmask = 8'hFF;
            tmask = tmask << k;
            ok = (c == tmask) && (b[k] == 8'hFD);
            for (int j = k + 1; j < 8; j++) if (b[j] != 8'h07) ok = 0;
            if (ok) begin
                p = 64'(tcode[k]);
                for (int j = 0; j < k; j++) p = p | (64'(b[j]) << (8 + 8*j));
                return {1'b0, p, 2'b10};
            end
        end
        p = 64'h1E;
        for (int i = 0; i < 8; i++) p = p | (64'h1E << (8 + 7*i));
        return {1'b1, p, 2'b10};
    endfunction

    // Drive one word until the modelled ready accepts it.
    task automatic send_word(input logic [31:0] w, input logic [3:0] c);
        bit   exp_rdy;
        bit   gb;
        bit   done;
        int   tries;
        logic [66:0] r;
        exp_t e;
        done  = 0;
        tries = 0;
        while (!done) begin
            @(negedge tx_clk);
            #1;
            in_xgmii_data  = w;
            in_xgmii_ctl   = c;
            in_xgmii_valid = 1'($urandom);
            case (gb_mode)
                0:       gb = 1;
                1:       gb = ($urandom_range(0, 9) < 7);
                default: begin
                    gb = (hold_left == 0);
                    if (hold_left > 0) hold_left--;
                end
            endcase
            in_gearbox_ready = gb;
            #1;
            exp_rdy = !(drv_phase == 1 && pending && !gb);
            check("pcs_ready", 66'(out_xgmii_pcs_ready), 66'(exp_rdy));
            if (exp_rdy) begin
                if (drv_phase == 0) begin
                    lo_word   = w;
                    lo_ctl    = c;
                    drv_phase = 1;
                    if (pending && gb) pending = 0;
                end else begin
                    r     = ref_encode({w, lo_word}, {c, lo_ctl});
                    e.blk = ovr_en ? ovr_blk : r[65:0];
                    e.err = ovr_en ? ovr_err : r[66];
                    exp_q.push_back(e);
                    drv_phase = 0;
                    pending   = 1;
                end
                done = 1;
            end
            tries++;
            if (!done && tries >= 64) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: got ready=0 for 64 cycles, want 1");
                done = 1;
            end
        end
    endtask

    task automatic send_col(input logic [63:0] d, input logic [7:0] c);
        send_word(d[31:0], c[3:0]);
        send_word(d[63:32], c[7:4]);
    endtask

    task automatic send_col_exp(input logic [63:0] d, input logic [7:0] c,
                                input logic [65:0] blk, input bit err);
        ovr_en  = 1;
        ovr_blk = blk;
        ovr_err = err;
        send_col(d, c);
        ovr_en  = 0;
    endtask

    // Random legal or illegal column.
    task automatic gen_col(output logic [63:0] d, output logic [7:0] c);
        logic [7:0] b [8];
        int         k;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        c = 8'h00;
        case ($urandom_range(0, 6))
            0: c = 8'h00;
            1: begin
                c = 8'hFF;
                for (int i = 0; i < 8; i++) b[i] = $urandom_range(0, 1) ? 8'hFE : 8'h07;
            end
            2: begin c = 8'h01; b[0] = 8'hFB; end
            3: begin
                c = 8'h1F;
                for (int i = 0; i < 4; i++) b[i] = 8'h07;
                b[4] = 8'hFB;
            end
            4: begin
                k = $urandom_range(0, 7);
                c = 8'hFF;
                c = c << k;
                b[k] = 8'hFD;
                for (int i = k + 1; i < 8; i++) b[i] = 8'h07;
            end
            5: begin
                k = $urandom_range(1, 7);
                c = 8'h00;
                c[k] = 1'b1;
                b[k] = $urandom_range(0, 1) ? 8'hFB : 8'hFD;
                if (b[k] == 8'hFD && k < 7) c = c | 8'h80;
            end
            default: begin
                c = 8'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    c = 8'hFF;
                    for (int i = 0; i < 8; i++) b[i] = 8'h07;
                    b[$urandom_range(0, 7)] = 8'h9C;
                end
            end
        endcase
        for (int i = 0; i < 8; i++) d[8*i +: 8] = b[i];
    endtask

    // Monitor: a block is new when valid follows an empty slot or a taken block.
    initial begin
        bit          last_valid = 0;
        bit          last_taken = 0;
        bit          nw;
        exp_t        e;
        logic [65:0] cur_blk = '0;
        forever begin
            @(negedge tx_clk);
            #3;
            if (!mon_en) begin
                last_valid = 0;
                last_taken = 0;
                continue;
            end
            nw = out_pcs_block_valid && (!last_valid || last_taken);
            if (nw) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_block: got %h, want no block", out_pcs_block);
                end else begin
                    e       = exp_q.pop_front();
                    cur_blk = e.blk;
                    check("block", out_pcs_block, e.blk);
                    check("err_pulse", 66'(out_encode_error), 66'(e.err));
                    if (e.err && model_cnt < CNT_MAX) model_cnt++;
                end
            end else begin
                check("err_quiet", 66'(out_encode_error), 66'(0));
                if (out_pcs_block_valid) check("hold_stable", out_pcs_block, cur_blk);
            end
            check("err_count", 66'(out_error_count), 66'(model_cnt));
            last_valid = out_pcs_block_valid;
            last_taken = out_pcs_block_valid && in_gearbox_ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    task automatic check_reset_state();
        check("rst_ready", 66'(out_xgmii_pcs_ready), 66'(0));
        check("rst_block", out_pcs_block, 66'(0));
        check("rst_valid", 66'(out_pcs_block_valid), 66'(0));
        check("rst_err", 66'(out_encode_error), 66'(0));
        check("rst_count", 66'(out_error_count), 66'(0));
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  c;
        logic [7:0]  m;

        tx_rst           = 1'b0;
        in_xgmii_data    = '0;
        in_xgmii_ctl     = '0;
        in_xgmii_valid   = 1'b0;
        in_gearbox_ready = 1'b1;
        repeat (3) @(negedge tx_clk);
        #1;
        check_reset_state();
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b1;
        mon_en = 1;

        // Directed columns with hand-derived blocks.
        gb_mode = 0;
        send_col_exp(64'h07070707_07070707, 8'hFF, {64'h0000_0000_0000_001E, 2'b10}, 0);
        send_col_exp(64'hD5555555_555555FB, 8'h01, {64'hD555_5555_5555_5578, 2'b10}, 0);
        send_col_exp(64'h555555FB_07070707, 8'h1F, {64'h5555_5500_0000_0033, 2'b10}, 0);
        send_col_exp(64'h070707FD_DDCCBBAA, 8'hF0, {64'h0000_00DD_CCBB_AACC, 2'b10}, 0);
        send_col_exp(64'h11223344_55667788, 8'h00, {64'h1122_3344_5566_7788, 2'b01}, 0);
        send_col(64'h88776655_44FB2211, 8'h04);

        // Terminate in every lane.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++)
                d[8*i +: 8] = (i < k) ? 8'(8'h30 + i) : ((i == k) ? 8'hFD : 8'h07);
            m = 8'hFF;
            c = m << k;
            send_col(d, c);
        end

        // Back-pressure: block 1 waits while words keep arriving.
        send_word(32'h03020100, 4'h0);
        gb_mode   = 2;
        hold_left = 6;
        send_word(32'h07060504, 4'h0);
        send_word(32'h0B0A0908, 4'h0);
        send_word(32'h0F0E0D0C, 4'h0);
        gb_mode = 0;

        // Random traffic with random gearbox back-pressure.
        gb_mode = 1;
        for (int n = 0; n < 300; n++) begin
            gen_col(d, c);
            send_col(d, c);
        end

        // Drive the count into saturation.
        gb_mode = 0;
        for (int n = 0; n < CNT_MAX + 2; n++) send_col(64'h88776655_44FB2211, 8'h04);

        // Reset with a low half held: it must be discarded.
        send_col(64'h07070707_07070707, 8'hFF);
        send_word(32'hAABBCCDD, 4'h0);
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        mon_en = 0;
        #1;
        check_reset_state();
        check("rst_queue_empty", 66'(exp_q.size()), 66'(0));
        exp_q.delete();
        drv_phase = 0;
        pending   = 0;
        model_cnt = 0;
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b1;
        mon_en = 1;
        send_col_exp(64'hD5555555_555555FB, 8'h01, {64'hD555_5555_5555_5578, 2'b10}, 0);
        send_col(64'h88776655_44FB2211, 8'h04);
        send_col(64'h07070707_07070707, 8'hFF);

        @(negedge tx_clk);
        #4;
        mon_en = 0;
        check("queue_drained", 66'(exp_q.size()), 66'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
